// File: rtl/core_fetch_pkg.sv
// Shared fetch-stage types: instruction/pointer widths, bus FSM states and the
// prefetch queue entry layout.
package core_fetch_pkg;

  typedef logic [30:0] hptr;
  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state;

  typedef struct packed {
    word insn;
    hptr pc;
  } fetch_entry;

  localparam int  FETCH_DEPTH = 4;
  localparam hptr RESET_PC    = '0;
  // One 32-bit instruction spans two halfwords.
  localparam hptr INSN_STEP   = 31'd2;

  function automatic hptr next_pc(input hptr pc);
    return pc + INSN_STEP;
  endfunction

endpackage

// File: rtl/core_fetch_if.sv
// Fetch-stage signal bundle: redirect input, instruction bus and decode side.
// master = the fetch stage, slave = its surroundings (branch unit, memory, decode).
interface core_fetch_if;
  import core_fetch_pkg::*;

  logic branch;
  hptr  target;
  logic fetch_req;
  hptr  fetch_addr;
  logic fetch_ready;
  word  fetch_data;
  logic decode_stall;
  logic insn_valid;
  word  insn;
  hptr  insn_pc;

  modport master (
    input  branch, target, fetch_ready, fetch_data, decode_stall,
    output fetch_req, fetch_addr, insn_valid, insn, insn_pc
  );

  modport slave (
    output branch, target, fetch_ready, fetch_data, decode_stall,
    input  fetch_req, fetch_addr, insn_valid, insn, insn_pc
  );

endinterface

// File: rtl/core_fetch_queue.sv
// Circular prefetch FIFO of fetch entries. Flush wins over push and pop;
// a push into a full queue is accepted only when a pop frees the slot.
module core_fetch_queue
  import core_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry               wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output fetch_entry               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry      mem [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign empty_o = empty;
  assign head_o  = mem[rd_ptr_q];

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC, runs the single-outstanding bus FSM and
// feeds decode from the prefetch queue. A redirect flushes and restarts fetch.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  core_fetch_if.master fif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state      state_q;
  hptr             pc_q;
  hptr             fetch_addr_q;
  logic            fetch_req_q;

  logic [CW-1:0]   count;
  logic            empty;
  logic            room;
  logic            pop;
  logic            push;
  fetch_entry      head;
  fetch_entry      push_entry;

  // The request test uses the settled count, so a pending slot is never over-committed.
  assign room       = (count < CW'(DEPTH));
  assign pop        = !empty && !fif.decode_stall;
  assign push       = (state_q == WAIT) && fif.fetch_ready && !fif.branch;
  assign push_entry = '{insn: fif.fetch_data, pc: pc_q};

  core_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (fif.branch),
    .count_o (count),
    .empty_o (empty),
    .head_o  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_PC;
    end else begin
      if (fif.branch) pc_q <= fif.target;
      case (state_q)
        IDLE: begin
          if (!fif.branch && room) begin
            fetch_req_q  <= 1'b1;
            fetch_addr_q <= pc_q;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (fif.fetch_ready) begin
            fetch_req_q <= 1'b0;
            state_q     <= IDLE;
            if (!fif.branch) pc_q <= next_pc(pc_q);
          end else if (fif.branch) begin
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          // Request stays up until the stale response retires it.
          if (fif.fetch_ready) begin
            fetch_req_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          fetch_req_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign fif.fetch_req  = fetch_req_q;
  assign fif.fetch_addr = fetch_addr_q;
  assign fif.insn_valid = !empty;
  assign fif.insn       = head.insn;
  assign fif.insn_pc    = head.pc;

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: a latency-programmable memory model, scoreboard
// queues of expected request addresses and delivered instructions, plus a queue unit check.
module tb_core_fetch;
  import core_fetch_pkg::*;

  logic clk;
  logic rst;

  core_fetch_if fif();

  core_fetch #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  logic       q_push, q_pop, q_flush, q_empty;
  fetch_entry q_wdata, q_head;
  logic [2:0] q_count;

  core_fetch_queue #(.DEPTH(4)) qdut (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .count_o (q_count),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

  int  total = 0;
  int  bad = 0;
  int  lat = 1;
  int  mem_cnt = 0;
  int  req_count = 0;
  bit  inj_rdy = 1'b0;
  bit  req_prev = 1'b0;
  bit  addr_chk = 1'b0;
  hptr last_exp_addr = '0;

  hptr        exp_addr[$];
  fetch_entry exp_insn[$];
  fetch_entry q_exp[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic word mem_word(input hptr a);
    case (a)
      31'd0:   return 32'h0000_0011;
      31'd2:   return 32'h0000_0022;
      31'd4:   return 32'h0000_0033;
      default: return {1'b1, a};
    endcase
  endfunction

  function automatic fetch_entry ent(input word w, input hptr p);
    fetch_entry e;
    e.insn = w;
    e.pc   = p;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory model: answers a held request after lat cycles; inj_rdy forces a stray strobe.
  initial begin
    fif.fetch_ready = 1'b0;
    fif.fetch_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      fif.fetch_ready = 1'b0;
      if (inj_rdy) begin
        fif.fetch_ready = 1'b1;
        fif.fetch_data  = 32'hDEAD_BEEF;
      end else if (!rst && fif.fetch_req) begin
        mem_cnt++;
        if (mem_cnt >= lat) begin
          fif.fetch_ready = 1'b1;
          fif.fetch_data  = mem_word(fif.fetch_addr);
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: new requests and decode pops are checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
      addr_chk = 1'b0;
    end else begin
      if (fif.fetch_req === 1'b1) begin
        if (!req_prev) begin
          req_count++;
          if (exp_addr.size() > 0) begin
            last_exp_addr = exp_addr.pop_front();
            addr_chk = 1'b1;
            check("fetch_addr", 64'(fif.fetch_addr), 64'(last_exp_addr));
          end else begin
            addr_chk = 1'b0;
          end
        end else if (addr_chk) begin
          check("addr_hold", 64'(fif.fetch_addr), 64'(last_exp_addr));
        end
      end
      if (fif.insn_valid === 1'b1 && !fif.decode_stall && !fif.branch && exp_insn.size() > 0)
        check("insn", 64'({fif.insn, fif.insn_pc}), 64'(exp_insn.pop_front()));
      req_prev = (fif.fetch_req === 1'b1);
    end
  end

  // Asserts reset at once (mid-transfer if fetch is running) and checks the outputs drop.
  task automatic do_reset(input int l, input bit inject);
    rst = 1'b1;
    #1;
    check("rst_req",    64'(fif.fetch_req),  64'd0);
    check("rst_addr",   64'(fif.fetch_addr), 64'd0);
    check("rst_valid",  64'(fif.insn_valid), 64'd0);
    check("rst_qcount", 64'(q_count),        64'd0);
    exp_addr.delete();
    exp_insn.delete();
    fif.branch = 1'b0;
    lat = l;
    tick(1);
    inj_rdy = inject;
    tick(1);
    rst = 1'b0;
    inj_rdy = 1'b0;
    req_count = 0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while ((exp_addr.size() != 0 || exp_insn.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(exp_addr.size() + exp_insn.size()), 64'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    fif.branch = 1'b0;
    fif.target = '0;
    fif.decode_stall = 1'b0;
    q_push = 1'b0;
    q_pop = 1'b0;
    q_flush = 1'b0;
    q_wdata = '0;
    tick(1);
    do_reset(1, 1'b0);

    // Queue unit: fill, push+pop while full, drain in order, flush priority
    for (int i = 0; i < 4; i++) begin
      q_wdata = ent(32'hA0 + 32'(i), 31'(2 * i));
      q_push = 1'b1;
      q_exp.push_back(q_wdata);
      tick(1);
    end
    q_push = 1'b0;
    check("q_full_count", 64'(q_count), 64'd4);
    check("q_full_empty", 64'(q_empty), 64'd0);
    q_wdata = ent(32'hA4, 31'd8);
    q_exp.push_back(q_wdata);
    q_push = 1'b1;
    q_pop = 1'b1;
    check("q_head", 64'(q_head), 64'(q_exp.pop_front()));
    tick(1);
    q_push = 1'b0;
    q_pop = 1'b0;
    check("q_pushpop_count", 64'(q_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("q_head", 64'(q_head), 64'(q_exp.pop_front()));
      q_pop = 1'b1;
      tick(1);
    end
    q_pop = 1'b0;
    check("q_drained_empty", 64'(q_empty), 64'd1);
    q_push = 1'b1;
    q_wdata = ent(32'hB0, 31'd0);
    tick(2);
    q_flush = 1'b1;
    q_pop = 1'b1;
    tick(1);
    q_push = 1'b0;
    q_pop = 1'b0;
    q_flush = 1'b0;
    check("q_flush_count", 64'(q_count), 64'd0);
    check("q_flush_empty", 64'(q_empty), 64'd1);

    // Reset and stream, with a stray strobe while idle right out of reset
    do_reset(1, 1'b1);
    fif.decode_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(31'(2 * i));
      exp_insn.push_back(ent(mem_word(31'(2 * i)), 31'(2 * i)));
    end
    tick(1);
    check("first_req",  64'(fif.fetch_req),  64'd1);
    check("first_addr", 64'(fif.fetch_addr), 64'd0);
    tick(1);
    check("ready_to_valid", 64'(fif.insn_valid), 64'd1);
    check("req_falls",      64'(fif.fetch_req),  64'd0);
    wait_drained("stream_done", 40);

    // Back-pressure: exactly DEPTH requests, then ordered drain and resume at 8
    do_reset(1, 1'b0);
    fif.decode_stall = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr.push_back(31'(2 * i));
    tick(20);
    check("bp_req_count", 64'(req_count),      64'd4);
    check("bp_req_low",   64'(fif.fetch_req),  64'd0);
    check("bp_head_pc",   64'(fif.insn_pc),    64'd0);
    for (int i = 0; i < 5; i++) exp_insn.push_back(ent(mem_word(31'(2 * i)), 31'(2 * i)));
    exp_addr.push_back(31'd8);
    fif.decode_stall = 1'b0;
    wait_drained("bp_drain", 60);

    // Redirect while waiting on a slow read
    do_reset(5, 1'b0);
    exp_addr.push_back(31'd0);
    exp_addr.push_back(31'h100);
    exp_insn.push_back(ent(mem_word(31'h100), 31'h100));
    tick(3);
    fif.branch = 1'b1;
    fif.target = 31'h100;
    tick(1);
    fif.branch = 1'b0;
    check("redir_valid",    64'(fif.insn_valid), 64'd0);
    check("discard_req",    64'(fif.fetch_req),  64'd1);
    check("discard_addr",   64'(fif.fetch_addr), 64'd0);
    wait_drained("redir_done", 60);

    // Branch coinciding with a response and a pop
    do_reset(2, 1'b0);
    fif.decode_stall = 1'b1;
    exp_addr.push_back(31'd0);
    exp_addr.push_back(31'd2);
    exp_addr.push_back(31'h40);
    exp_insn.push_back(ent(mem_word(31'h40), 31'h40));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (fif.fetch_ready === 1'b1 && fif.insn_valid === 1'b1) found = 1'b1;
    end
    check("simul_setup", 64'(found), 64'd1);
    fif.branch = 1'b1;
    fif.target = 31'h40;
    fif.decode_stall = 1'b0;
    tick(1);
    fif.branch = 1'b0;
    check("simul_flushed", 64'(fif.insn_valid), 64'd0);
    check("simul_idle",    64'(fif.fetch_req),  64'd0);
    tick(1);
    check("simul_req",  64'(fif.fetch_req),  64'd1);
    check("simul_addr", 64'(fif.fetch_addr), 64'h40);
    wait_drained("simul_done", 40);

    // Reset-vector redirect near the top of the space, then silent wrap to 0
    do_reset(1, 1'b0);
    fif.branch = 1'b1;
    fif.target = 31'h7FFF_FFFE;
    exp_addr.push_back(31'h7FFF_FFFE);
    exp_addr.push_back(31'd0);
    exp_insn.push_back(ent(mem_word(31'h7FFF_FFFE), 31'h7FFF_FFFE));
    exp_insn.push_back(ent(mem_word(31'd0), 31'd0));
    tick(1);
    fif.branch = 1'b0;
    check("vec_no_req", 64'(fif.fetch_req), 64'd0);
    wait_drained("wrap_done", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
